// File: rtl/lfsr_pkg.sv
// Shared constants and next-state function for the 8-bit Galois LFSR.
// Benches may call lfsr_next directly as a reference step.
package lfsr_pkg;

    localparam logic [7:0] DEFAULT_SEED     = 8'h80;
    localparam logic [7:0] DEFAULT_TAP_MASK = 8'h83;

    // Right-shifting Galois step: the bit shifted out of q[0] decides whether the mask toggles.
    function automatic logic [7:0] lfsr_next(input logic [7:0] state, input logic [7:0] mask);
        return (state >> 1) ^ (state[0] ? mask : 8'h00);
    endfunction

endpackage

// File: rtl/lfsr_8bit.sv
// 8-bit right-shifting Galois LFSR with synchronous active-low reset to SEED.
// The output comes straight from the state register.
module lfsr_8bit
    import lfsr_pkg::*;
#(
    parameter logic [7:0] SEED     = DEFAULT_SEED,
    parameter logic [7:0] TAP_MASK = DEFAULT_TAP_MASK
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    // A zero seed would lock the register at zero; a clear mask bit 7 would make the step non-invertible.
    if (SEED == 8'h00) begin : g_bad_seed
        $error("lfsr_8bit: SEED must be nonzero");
    end
    if (TAP_MASK[7] != 1'b1) begin : g_bad_mask
        $error("lfsr_8bit: TAP_MASK bit 7 must be set");
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= SEED;
        end else begin
            q <= lfsr_next(q, TAP_MASK);
        end
    end

endmodule

// File: tb/tb_lfsr_8bit.sv
// Self-checking bench for lfsr_8bit: directed sequences, random reset pulses
// against an arithmetic model, and period measurement over two free runs.
module tb_lfsr_8bit;
    import lfsr_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] q;
    logic [7:0] q_seed1;

    int compared   = 0;
    int mismatched = 0;

    lfsr_8bit dut (
        .clk (clk),
        .rst (rst),
        .q   (q)
    );

    lfsr_8bit #(.SEED(8'h01)) dut_seed1 (
        .clk (clk),
        .rst (rst),
        .q   (q_seed1)
    );

    always #5 clk = ~clk;

    // Reference step with integer arithmetic: halve, and fold in 0x83 when the dropped bit was odd.
    function automatic int model_step(input int s);
        int r;
        r = s / 2;
        if ((s % 2) != 0) r = r ^ 131;
        return r;
    endfunction

    task automatic applyStimulus(input logic rst_val);
        rst = rst_val;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic free_run(input string tag, output int period);
        logic [7:0] prev;
        applyStimulus(1'b0);
        checkOutput({tag, "_reset"}, q, 8'h80);
        prev   = q;
        period = 0;
        for (int i = 1; i <= 600; i++) begin
            applyStimulus(1'b1);
            checkOutput({tag, "_next"}, q, lfsr_next(prev, DEFAULT_TAP_MASK));
            checkOutput({tag, "_nonzero"}, {31'd0, q == 8'h00}, 32'd0);
            if (period == 0 && q == 8'h80) period = i;
            prev = q;
        end
    endtask

    initial begin
        logic [7:0] exp_seq [10];
        int         m;
        int         model_period;
        int         period_a;
        int         period_b;
        logic       r;
        logic [7:0] s;

        exp_seq = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h83, 8'hC2, 8'h61};

        // Reset held low across three edges.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0);
            checkOutput("reset_hold", q, 8'h80);
            checkOutput("seed1_reset", q_seed1, 8'h01);
        end

        // Default sequence from SEED, plus the SEED=01 instance's first step.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1);
            checkOutput("default_seq", q, exp_seq[i]);
            if (i == 0) checkOutput("seed1_step", q_seed1, 8'h83);
        end

        // Reset mid-sequence while q is 04.
        applyStimulus(1'b0);
        checkOutput("rerun_reset", q, 8'h80);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1);
            checkOutput("rerun_seq", q, exp_seq[i]);
        end
        applyStimulus(1'b0);
        checkOutput("mid_reset", q, 8'h80);
        applyStimulus(1'b1);
        checkOutput("after_mid_reset", q, 8'h40);

        // Package function against the arithmetic model, including the zero fixed point.
        checkOutput("zero_stays_zero", lfsr_next(8'h00, DEFAULT_TAP_MASK), 8'h00);
        for (int i = 0; i < 8; i++) begin
            s = 8'($urandom_range(0, 255));
            checkOutput("pkg_vs_model", lfsr_next(s, DEFAULT_TAP_MASK), 32'(model_step(int'(s))));
        end

        // Random reset pulses tracked by the model.
        applyStimulus(1'b0);
        m = 128;
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 19) != 0);
            applyStimulus(r);
            m = r ? model_step(m) : 128;
            checkOutput("random_model", q, 32'(m));
            checkOutput("random_nonzero", {31'd0, q == 8'h00}, 32'd0);
        end

        // Period from the model, then measured twice on the DUT.
        m = model_step(128);
        model_period = 1;
        while (m != 128 && model_period < 300) begin
            m = model_step(m);
            model_period++;
        end

        free_run("run_a", period_a);
        free_run("run_b", period_b);
        checkOutput("period_a", period_a, model_period);
        checkOutput("period_b", period_b, model_period);
        checkOutput("period_match", period_a, period_b);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lfsr_8bit.md
LFSR_8BIT -- requirements
Module: lfsr_8bit

Interface
- REQ-001: Parameter SEED SHALL default to 8'h80 and set the state loaded on reset; it SHALL be nonzero.
- REQ-002: Parameter TAP_MASK SHALL default to 8'h83 and set the Galois toggle mask applied when the shifted-out bit is 1.
- REQ-003: Port `clk`, input, width 1, SHALL be the single clock; all state updates occur on its rising edge.
- REQ-004: Port `rst`, input, width 1, SHALL be the reset; it is synchronous and active-low, sampled on the `clk` rising edge.
- REQ-005: Port `q`, output, width 8, SHALL present the current LFSR state directly from a register.

Function
- REQ-006: The block SHALL hold one 8-bit state register driving `q` with zero combinational logic on the output path.
- REQ-007: Each rising edge with `rst`=1 SHALL load next = (q >> 1) XOR (q[0] ? TAP_MASK : 8'h00), a right-shifting Galois LFSR.
- REQ-008: With default parameters, the sequence from SEED SHALL be 80, 40, 20, 10, 08, 04, 02, 01, 83, C2, 61, ... (hex).
- REQ-009: The state SHALL advance every cycle; the block has no enable or hold input.
- REQ-010: `q` SHALL change exactly one cycle after each qualifying edge, with latency 1 and no pipeline.
- REQ-011: A nonzero state SHALL never transition to 8'h00, because TAP_MASK bit 7 is set and the update is invertible.
- REQ-012: If the state is ever 8'h00, it SHALL remain 8'h00 until reset; no lock-up recovery is required.
- REQ-013: The sequence SHALL be periodic and deterministic; maximal length (255) is not required with TAP_MASK=8'h83.

Reset
- REQ-014: A rising edge with `rst`=0 SHALL load SEED (8'h80 by default), regardless of the current state.
- REQ-015: Reset SHALL take priority over the shift update on the same edge.
- REQ-016: While `rst` is held low, `q` SHALL stay at SEED.
- REQ-017: Asserting reset mid-sequence SHALL restart the sequence from SEED on the next edge.
- REQ-018: Before the first reset edge `q` is undefined; the bench SHALL apply reset before checking values.

Structure
- REQ-019: The defaults SEED=8'h80 and TAP_MASK=8'h83 SHALL be defined as constants in the shared package `lfsr_pkg`.
- REQ-020: The next-state computation SHALL be a pure function `lfsr_next(state, mask)` in `lfsr_pkg`, reusable by benches as a reference model.
- REQ-021: No sub-module is needed; the block is one flat module with a single register process.
- REQ-022: The RTL SHALL include parameter legality checks (SEED nonzero, TAP_MASK[7]=1) as elaboration-time assertions.

Verification
- REQ-023: Hold `rst`=0 for 3 edges -> `q`=8'h80 after each edge.
- REQ-024: Release reset and apply 8 edges -> `q` = 40, 20, 10, 08, 04, 02, 01, 83 in order.
- REQ-025: Apply 2 more edges after 8'h83 -> `q` = 8'hC2, then 8'h61.
- REQ-026: Assert `rst`=0 for one edge while `q`=8'h04 -> `q`=8'h80 on that edge, then 8'h40 on the next edge with `rst`=1.
- REQ-027: Run 600 free-running cycles after reset -> every `q` matches `lfsr_next` applied to the prior `q`, `q` is never 8'h00, and the first repeat of 8'h80 gives a fixed period that is identical across two runs.
- REQ-028: Override SEED=8'h01 -> `q`=8'h01 after reset, then 8'h83 on the next edge.
